// File: rtl/mm_uart_arb_pkg.sv
// Shared types and sizing helpers for the UART port arbiter.
package mm_uart_arb_pkg;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_RD_RESP = 1'b1
    } arb_state_t;

    // Ceiling log2; returns 0 for inputs of 0 or 1.
    function automatic int unsigned log2_ceil(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        return r;
    endfunction

    // Index width that never collapses to zero bits.
    function automatic int unsigned idx_width(input int unsigned v);
        return (v < 2) ? 1 : log2_ceil(v);
    endfunction

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin picker: first set request at or after the pointer.
module rr_select #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 2
) (
    input  logic [N-1:0] i_req,
    input  logic [W-1:0] i_ptr,
    output logic [N-1:0] o_grant,
    output logic [W-1:0] o_idx,
    output logic         o_valid
);

    always_comb begin : sel
        int unsigned c;
        c       = 0;
        o_grant = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            c = (32'(i_ptr) + k) % N;
            if (!o_valid && i_req[W'(c)]) begin
                o_valid          = 1'b1;
                o_grant[W'(c)]   = 1'b1;
                o_idx            = W'(c);
            end
        end
    end

endmodule

// File: rtl/mm_uart_arbiter.sv
// Round-robin arbiter sharing the UART memory-mapped port between requesters,
// with optional ownership lock and idle-timeout release.
module mm_uart_arbiter
    import mm_uart_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned LOCK_TIMEOUT = 64
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [NUM_REQ-1:0]                 req_read,
    input  logic [NUM_REQ-1:0]                 req_write,
    input  logic [NUM_REQ-1:0]                 req_lock,
    input  logic [NUM_REQ*(DATA_WIDTH/8)-1:0]  req_byte_en,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]      req_address,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]      req_write_data,
    output logic [NUM_REQ-1:0]                 req_ready,
    output logic [NUM_REQ-1:0]                 req_read_valid,
    output logic [DATA_WIDTH-1:0]              req_read_data,
    output logic                               readEnable,
    output logic                               writeEnable,
    output logic [DATA_WIDTH/8-1:0]            writeByteEnable,
    output logic [ADDR_WIDTH-1:0]              address,
    output logic [DATA_WIDTH-1:0]              writeData,
    input  logic [DATA_WIDTH-1:0]              readData
);

    localparam int unsigned BE_W  = DATA_WIDTH / 8;
    localparam int unsigned PTR_W = idx_width(NUM_REQ);
    localparam int unsigned CNT_W = idx_width(LOCK_TIMEOUT + 1);

    arb_state_t         r_state, w_state_nxt;
    logic [PTR_W-1:0]   r_ptr, w_ptr_nxt;
    logic               r_locked, w_locked_nxt;
    logic [PTR_W-1:0]   r_owner, w_owner_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [PTR_W-1:0]   r_rd_owner, w_rd_owner_nxt;

    logic [NUM_REQ-1:0] w_active;
    logic [NUM_REQ-1:0] w_owner_onehot;
    logic               w_owner_active;
    logic               w_owner_lock;
    logic               w_lock_hold;
    logic [NUM_REQ-1:0] w_eligible;
    logic [NUM_REQ-1:0] w_grant;
    logic [PTR_W-1:0]   w_gidx;
    logic               w_gvalid;
    logic               w_gwrite;
    logic               w_glock;

    logic [ADDR_WIDTH-1:0] w_addr  [NUM_REQ];
    logic [DATA_WIDTH-1:0] w_wdata [NUM_REQ];
    logic [BE_W-1:0]       w_be    [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign w_addr[g]  = req_address[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign w_wdata[g] = req_write_data[g*DATA_WIDTH +: DATA_WIDTH];
        assign w_be[g]    = req_byte_en[g*BE_W +: BE_W];
    end

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] idx);
        return (idx == PTR_W'(NUM_REQ - 1)) ? '0 : idx + PTR_W'(1);
    endfunction

    // Lock persists while the owner keeps req_lock high or is issuing its final access.
    assign w_active       = req_read | req_write;
    assign w_owner_onehot = NUM_REQ'(1) << r_owner;
    assign w_owner_active = |(w_active & w_owner_onehot);
    assign w_owner_lock   = |(req_lock & w_owner_onehot);
    assign w_lock_hold    = r_locked && (w_owner_lock || w_owner_active);
    assign w_eligible     = (reset && (r_state == ST_IDLE))
                          ? (w_lock_hold ? (w_active & w_owner_onehot) : w_active)
                          : '0;

    rr_select #(
        .N (NUM_REQ),
        .W (PTR_W)
    ) u_rr_select (
        .i_req   (w_eligible),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_gidx),
        .o_valid (w_gvalid)
    );

    assign w_gwrite = |(req_write & w_grant);
    assign w_glock  = |(req_lock & w_grant);

    // UART strobes and requester handshakes follow the grant / response state directly.
    always_comb begin
        req_ready       = w_grant;
        writeEnable     = w_gvalid && w_gwrite;
        readEnable      = w_gvalid && !w_gwrite;
        address         = w_gvalid ? w_addr[w_gidx]  : '0;
        writeData       = w_gvalid ? w_wdata[w_gidx] : '0;
        writeByteEnable = w_gvalid ? w_be[w_gidx]    : '0;
        req_read_valid  = '0;
        req_read_data   = '0;
        if (reset && (r_state == ST_RD_RESP)) begin
            req_read_valid[r_rd_owner] = 1'b1;
            req_read_data              = readData;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_ptr_nxt      = r_ptr;
        w_locked_nxt   = r_locked;
        w_owner_nxt    = r_owner;
        w_cnt_nxt      = r_cnt;
        w_rd_owner_nxt = r_rd_owner;
        case (r_state)
            ST_IDLE: begin
                if (r_locked) begin
                    if (!w_lock_hold) begin
                        w_locked_nxt = 1'b0;
                        w_cnt_nxt    = '0;
                        w_ptr_nxt    = ptr_inc(r_owner);
                    end else if (!w_owner_active) begin
                        if (r_cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
                            w_locked_nxt = 1'b0;
                            w_cnt_nxt    = '0;
                            w_ptr_nxt    = ptr_inc(r_owner);
                        end else begin
                            w_cnt_nxt = r_cnt + CNT_W'(1);
                        end
                    end
                end
                // A grant overrides any release bookkeeping from above.
                if (w_gvalid) begin
                    if (w_glock) begin
                        w_locked_nxt = 1'b1;
                        w_owner_nxt  = w_gidx;
                        w_cnt_nxt    = '0;
                    end else begin
                        w_ptr_nxt = ptr_inc(w_gidx);
                        if (r_locked && (w_gidx == r_owner)) begin
                            w_locked_nxt = 1'b0;
                            w_cnt_nxt    = '0;
                        end
                    end
                    if (!w_gwrite) begin
                        w_state_nxt    = ST_RD_RESP;
                        w_rd_owner_nxt = w_gidx;
                    end
                end
            end
            ST_RD_RESP: w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_ptr      <= '0;
            r_locked   <= 1'b0;
            r_owner    <= '0;
            r_cnt      <= '0;
            r_rd_owner <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_ptr      <= w_ptr_nxt;
            r_locked   <= w_locked_nxt;
            r_owner    <= w_owner_nxt;
            r_cnt      <= w_cnt_nxt;
            r_rd_owner <= w_rd_owner_nxt;
        end
    end

endmodule
